mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arb_rr.sv | 21 ++
 rtl/mem_arbiter.sv | 118 +++++++++++
 tb/tb_mem_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM type, requester indices and default timing for the memory arbiter
// Contents:
//   state_e      - arbiter FSM states (IDLE / ISSUE / WAIT)
//   REQ_CPU/DMA  - requester bit positions in every 2-bit per-requester vector
//   DEF_MEM_LAT  - default memory latency in cycles (mem_en to valid mem_data)
//   DEF_TIMEOUT  - default cap on consecutive locked transactions
package mem_arb_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;
  localparam int REQ_CPU     = 0;
  localparam int REQ_DMA     = 1;
  localparam int DEF_MEM_LAT = 2;
  localparam int DEF_TIMEOUT = 4;
endpackage

// File: rtl/mem_arb_rr.sv
// mem_arb_rr: two-way round-robin pick of one requester
// Ports:
//   req_i  - raw requests, one bit per requester
//   mask_i - requesters excluded from this pick
//   ptr_i  - index of the requester served last
//   win_o  - one-hot winner, zero when nothing eligible
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic [1:0] mask_i,
  input  logic       ptr_i,
  output logic [1:0] win_o
);
  logic [1:0] eff;
  always_comb begin
    eff   = req_i & ~mask_i;
    // on a tie the requester not served last wins
    win_o = (&eff) ? (ptr_i ? 2'(1 << REQ_CPU) : 2'(1 << REQ_DMA)) : eff;
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin arbiter for a single fixed-latency memory port
// Optional feature macro: MEM_ARB_TIMEOUT_EN (caps consecutive locked transactions at TIMEOUT
// when the other requester is waiting; without it lock is honoured indefinitely).
// Ports:
//   clk_i, rst_ni       - rising-edge clock, asynchronous active-low reset
//   req_i, rw_i, lock_i - per-requester request, direction (1=read), hold-grant
//   addr_i, wdata_i     - packed per-requester address/write data, requester i at [32i+31:32i]
//   gnt_o, ack_o        - one-hot grant (ISSUE through ack), one-cycle completion pulse
//   rdata_o             - read data, valid in the ack cycle and held until the next read ack
//   mem_en_o, mem_rw_o, mem_addr_o, mem_datao_o, mem_data_i - memory side
//   busy_o              - high whenever the FSM is not IDLE
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = DEF_MEM_LAT,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [1:0]  req_i,
  input  logic [1:0]  rw_i,
  input  logic [63:0] addr_i,
  input  logic [63:0] wdata_i,
  input  logic [1:0]  lock_i,
  output logic [1:0]  gnt_o,
  output logic [1:0]  ack_o,
  output logic [31:0] rdata_o,
  output logic        mem_en_o,
  output logic        mem_rw_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_datao_o,
  input  logic [31:0] mem_data_i,
  output logic        busy_o
);
  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d, gnt_q, gnt_d, mask, win;
  logic        ptr_q, ptr_d, rw_q, rw_d, last, own, hold, to, grant;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;

  if (MEM_LAT < 1 || MEM_LAT > 4 || TIMEOUT < 1) begin : g_bad_param
    $error("mem_arbiter: MEM_LAT must be 1..4 and TIMEOUT at least 1");
  end

  assign own  = gnt_q[REQ_DMA];
  assign last = (state_q == WAIT) && (cnt_q == 2'(MEM_LAT - 1));

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int LW = $clog2(TIMEOUT + 1);
  logic [LW-1:0] lk_q, lk_d;
  // lk_q counts transactions of the current owner; it saturates at TIMEOUT
  assign to = (lk_q >= LW'(TIMEOUT)) && req_i[~own];
  always_comb
    lk_d = (state_d != ISSUE) ? ((state_d == IDLE) ? '0 : lk_q) :
           (state_q == WAIT && win == gnt_q) ? ((lk_q >= LW'(TIMEOUT)) ? lk_q : lk_q + 1'b1) :
           LW'(1);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) lk_q <= '0;
    else lk_q <= lk_d;
`else
  assign to = 1'b0;
`endif

  // a held lock masks the other requester so the owner is re-picked
  assign hold = lock_i[own] & req_i[own] & ~to;
  assign mask = (state_q == WAIT) ? (hold ? ~gnt_q : gnt_q) : 2'b00;

  mem_arb_rr u_rr (
    .req_i (req_i),
    .mask_i(mask),
    .ptr_i (ptr_q),
    .win_o (win)
  );

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gnt_q   <= '0;
      ptr_q   <= 1'b1;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end

  always_comb begin
    grant   = (state_q == IDLE || last) && |win;
    state_d = grant ? ISSUE : (state_q == ISSUE) ? WAIT : (state_q == IDLE || last) ? IDLE : WAIT;
    cnt_d   = (state_q == WAIT) ? cnt_q + 2'd1 : 2'd0;
    gnt_d   = grant ? win : last ? 2'b00 : gnt_q;
    ptr_d   = grant ? win[REQ_DMA] : ptr_q;
    rw_d    = grant ? rw_i[win[REQ_DMA]] : rw_q;
    addr_d  = grant ? (win[REQ_DMA] ? addr_i[63:32] : addr_i[31:0]) : addr_q;
    wdata_d = grant ? (win[REQ_DMA] ? wdata_i[63:32] : wdata_i[31:0]) : wdata_q;
    rdata_d = (last && rw_q) ? mem_data_i : rdata_q;
  end

  always_comb begin
    busy_o      = state_q != IDLE;
    gnt_o       = gnt_q;
    ack_o       = last ? gnt_q : 2'b00;
    mem_en_o    = state_q == ISSUE;
    mem_rw_o    = busy_o & rw_q;
    mem_addr_o  = busy_o ? addr_q : '0;
    mem_datao_o = busy_o ? wdata_q : '0;
    // memory data arrives in the ack cycle itself, so pass it straight through then
    rdata_o     = (last && rw_q) ? mem_data_i : rdata_q;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter (vector table, corner sequences, random vs model)
module tb_mem_arbiter;
  localparam int L  = 2;
  localparam int TO = 4;

  logic        clk = 1'b0, rst_n;
  logic [1:0]  req, rw, lock, gnt, ack;
  logic [63:0] addr, wdata;
  logic [31:0] rdata, mem_addr, mem_datao, mem_data;
  logic        mem_en, mem_rw, busy;
  int          n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LAT(L), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .rw_i(rw), .addr_i(addr), .wdata_i(wdata),
    .lock_i(lock), .gnt_o(gnt), .ack_o(ack), .rdata_o(rdata), .mem_en_o(mem_en),
    .mem_rw_o(mem_rw), .mem_addr_o(mem_addr), .mem_datao_o(mem_datao), .mem_data_i(mem_data),
    .busy_o(busy)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : a * 32'h9E3779B1 + 32'h01234567;
  endfunction

  // memory: data for an address becomes valid exactly L cycles after its mem_en cycle
  logic        pv [L];
  logic [31:0] pa [L];
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int k = 0; k < L; k++) begin pv[k] <= 1'b0; pa[k] <= '0; end
    end else begin
      pv[0] <= mem_en;
      pa[0] <= mem_addr;
      for (int k = 1; k < L; k++) begin pv[k] <= pv[k-1]; pa[k] <= pa[k-1]; end
    end
  assign mem_data = pv[L-1] ? memf(pa[L-1]) : 32'h0BAD0BAD;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference model: cycles left in the current transaction (L+1 = issue cycle, 1 = ack cycle)
  int          m_left, m_own, m_ptr, m_cnt;
  logic        m_rw;
  logic [31:0] m_addr, m_wd, m_rdata;

  task automatic m_reset();
    m_left = 0; m_own = 0; m_ptr = 1; m_cnt = 0;
    m_rw = 0; m_addr = 0; m_wd = 0; m_rdata = 0;
  endtask

  task automatic m_check(input string tag);
    logic [1:0] g;
    g = (m_left > 0) ? 2'(1 << m_own) : 2'b00;
    check({tag, " busy"}, busy, m_left > 0);
    check({tag, " gnt"}, gnt, g);
    check({tag, " ack"}, ack, (m_left == 1) ? g : 2'b00);
    check({tag, " mem_en"}, mem_en, m_left == L + 1);
    check({tag, " mem_rw"}, mem_rw, (m_left > 0) && m_rw);
    check({tag, " mem_addr"}, mem_addr, (m_left > 0) ? m_addr : 32'h0);
    check({tag, " mem_datao"}, mem_datao, (m_left > 0) ? m_wd : 32'h0);
    check({tag, " rdata"}, rdata, (m_left == 1 && m_rw) ? memf(m_addr) : m_rdata);
  endtask

  task automatic m_step();
    int c, w;
    logic t;
    if (m_left > 1) begin m_left--; return; end
    if (m_left == 1 && m_rw) m_rdata = memf(m_addr);
    c = int'(req);
    t = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    t = (m_left == 1) && (m_cnt >= TO) && req[1 - m_own];
`endif
    if (m_left == 1 && lock[m_own] && req[m_own] && !t) w = m_own;
    else begin
      if (m_left == 1) c = c & ~(1 << m_own);
      w = (c == 3) ? 1 - m_ptr : (c == 2) ? 1 : (c == 1) ? 0 : -1;
    end
    if (w < 0) begin m_left = 0; return; end
    m_cnt  = (m_left == 1 && w == m_own) ? ((m_cnt < TO) ? m_cnt + 1 : TO) : 1;
    m_own  = w;
    m_ptr  = w;
    m_left = L + 1;
    m_rw   = rw[w];
    m_addr = addr[32*w +: 32];
    m_wd   = wdata[32*w +: 32];
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req = 0; rw = 0; lock = 0; addr = 0; wdata = 0;
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
  endtask

  task automatic scramble();
    req = 0; rw = ~rw; lock = 0;
    addr = {$urandom, $urandom}; wdata = {$urandom, $urandom};
  endtask

  typedef struct {
    logic [1:0]  req, rw;
    logic [63:0] addr, wdata;
    logic [1:0]  gnt;
    logic        mrw;
    logic [31:0] maddr, mdata, rdata;
  } vec_t;
  vec_t tv [6];

  logic [1:0] eg [6], ea [6];
  logic       ee [6];
  logic       seen1;
  int         n0;

  initial begin
    rst_n = 1'b0; req = 0; rw = 0; lock = 0; addr = 0; wdata = 0;
    m_reset();
    #12;
    check("reset busy", busy, 1'b0);
    check("reset gnt", gnt, 2'b00);
    check("reset mem_en", mem_en, 1'b0);
    check("reset rdata", rdata, 32'h0);

    tv[0] = '{2'b01, 2'b01, {32'h0, 32'h10}, 64'h0, 2'b01, 1'b1, 32'h10, 32'h0, 32'hDEADBEEF};
    tv[1] = '{2'b10, 2'b00, {32'h20, 32'h0}, {32'h55, 32'h0}, 2'b10, 1'b0, 32'h20, 32'h55, 32'h0};
    tv[2] = '{2'b11, 2'b11, {32'h200, 32'h100}, {32'h2, 32'h1}, 2'b01, 1'b1, 32'h100, 32'h1, memf(32'h100)};
    tv[3] = '{2'b11, 2'b10, {32'h300, 32'h400}, {32'hBEEF, 32'hCAFE}, 2'b01, 1'b0, 32'h400, 32'hCAFE, 32'h0};
    tv[4] = '{2'b10, 2'b10, {32'h30, 32'h40}, {32'h7, 32'h8}, 2'b10, 1'b1, 32'h30, 32'h7, memf(32'h30)};
    tv[5] = '{2'b00, 2'b11, {32'h50, 32'h60}, 64'h0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0};
    for (int i = 0; i < 6; i++) begin
      do_reset();
      req = tv[i].req; rw = tv[i].rw; addr = tv[i].addr; wdata = tv[i].wdata;
      @(negedge clk);
      check($sformatf("vec%0d gnt", i), gnt, tv[i].gnt);
      check($sformatf("vec%0d mem_en", i), mem_en, |tv[i].gnt);
      check($sformatf("vec%0d mem_rw", i), mem_rw, tv[i].mrw);
      check($sformatf("vec%0d mem_addr", i), mem_addr, tv[i].maddr);
      check($sformatf("vec%0d mem_datao", i), mem_datao, tv[i].mdata);
      scramble();
      repeat (L) @(negedge clk);
      check($sformatf("vec%0d ack", i), ack, tv[i].gnt);
      check($sformatf("vec%0d rdata", i), rdata, tv[i].rdata);
      @(negedge clk);
      check($sformatf("vec%0d idle busy", i), busy, 1'b0);
      check($sformatf("vec%0d idle rdata", i), rdata, tv[i].rdata);
    end

    // tie after reset: requester 0 first, requester 1 issued right after the first ack
    eg = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10};
    ea = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10};
    ee = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    do_reset();
    req = 2'b11; rw = 2'b11; addr = {32'h200, 32'h100};
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("tie c%0d gnt", c + 1), gnt, eg[c]);
      check($sformatf("tie c%0d ack", c + 1), ack, ea[c]);
      check($sformatf("tie c%0d mem_en", c + 1), mem_en, ee[c]);
    end
    check("tie rdata req1", rdata, memf(32'h200));
    req = 0;
    repeat (L + 2) @(negedge clk);

    // lock held by requester 0 while requester 1 waits
    do_reset();
    req = 2'b11; rw = 2'b11; lock = 2'b01; seen1 = 1'b0; n0 = 0;
    for (int c = 0; c < 60 && !seen1; c++) begin
      @(negedge clk);
      if (gnt[1]) seen1 = 1'b1;
      else if (ack == 2'b01) n0++;
    end
`ifdef MEM_ARB_TIMEOUT_EN
    check("lock req0 acks before gnt1", n0, TO);
    check("lock gnt1 seen", seen1, 1'b1);
`else
    check("lock gnt1 never", seen1, 1'b0);
    check("lock req0 acks", n0 > 10, 1'b1);
`endif
    req = 0; lock = 0;
    repeat (2 * L + 4) @(negedge clk);

    // reset in the middle of WAIT
    do_reset();
    req = 2'b01; rw = 2'b01; addr = {32'h0, 32'h10};
    repeat (L + 1) @(negedge clk);
    check("rst pre ack", ack, 2'b01);
    check("rst pre rdata", rdata, 32'hDEADBEEF);
    addr = {32'h0, 32'h44};
    @(negedge clk);
    check("rst bubble busy", busy, 1'b0);
    @(negedge clk);
    check("rst 2nd mem_addr", mem_addr, 32'h44);
    req = 0;
    @(negedge clk);
    check("rst in wait busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst busy", busy, 1'b0);
    check("rst gnt", gnt, 2'b00);
    check("rst ack", ack, 2'b00);
    check("rst mem_en", mem_en, 1'b0);
    check("rst mem_rw", mem_rw, 1'b0);
    check("rst mem_addr", mem_addr, 32'h0);
    check("rst mem_datao", mem_datao, 32'h0);
    check("rst rdata", rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < L + 2; c++) begin
      @(negedge clk);
      check($sformatf("rst no ack c%0d", c), ack, 2'b00);
    end
    req = 2'b01; addr = {32'h0, 32'h10};
    @(negedge clk);
    check("post rst gnt", gnt, 2'b01);
    check("post rst mem_en", mem_en, 1'b1);
    req = 0;
    repeat (L) @(negedge clk);
    check("post rst ack", ack, 2'b01);
    check("post rst rdata", rdata, 32'hDEADBEEF);

    // random traffic against the reference model
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if (c > 0) @(negedge clk);
      req   = 2'($urandom_range(0, 3));
      rw    = 2'($urandom_range(0, 3));
      lock  = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      addr  = {$urandom, ($urandom_range(0, 7) == 0) ? 32'h10 : $urandom};
      wdata = {$urandom, $urandom};
      #1;
      m_check($sformatf("rnd%0d", c));
      @(posedge clk);
      m_step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
